tx_frame_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single AXI-Stream byte input of packet_tx between NUM_SRC frame sources (e.g. ARP responder, UDP engine, CPU path). It grants one source at a time, holds the grant until that source's tlast beat completes, and inserts a programmable idle gap before the next grant. It sits directly upstream of packet_tx, and its master port connects to packet_tx's s_axis_* inputs.

---
 rtl/tx_frame_arbiter.sv | 144 ++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Packet-level round-robin arbiter feeding packet_tx. It locks one source for a
// whole frame, then forces GAP_CYCLES idle cycles before the next arbitration.
module tx_frame_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_SRC-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_SRC - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             any_req;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end

    // Scan nearest-last so the first requester after the pointer wins.
    always_comb begin
        any_req = 1'b0;
        pick    = ptr_q;
        cand    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (s_axis_tvalid[cand[IDX_W-1:0]]) begin
                any_req = 1'b1;
                pick    = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = s_axis_tdata[8*i +: 8];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (sel_valid && sel_last && m_axis_tready) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pure combinational pass-through of the granted source while in SEND.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (state_q == SEND) begin
            m_axis_tdata  = sel_data;
            m_axis_tvalid = sel_valid;
            m_axis_tlast  = sel_last;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: one instance with a 4-cycle gap, one
// with no gap, driven by simple per-source frame generators.
module tb_tx_frame_arbiter;

    logic        clk;
    logic        rst;

    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        grant;
    logic        busy;

    logic [15:0] s_tdata_z;
    logic [1:0]  s_tvalid_z;
    logic [1:0]  s_tlast_z;
    logic [1:0]  s_tready_z;
    logic [7:0]  m_tdata_z;
    logic        m_tvalid_z;
    logic        m_tlast_z;
    logic        m_tready_z;
    logic        grant_z;
    logic        busy_z;

    tx_frame_arbiter #(.NUM_SRC(2), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .grant_id(grant), .busy(busy)
    );

    tx_frame_arbiter #(.NUM_SRC(2), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata_z), .s_axis_tvalid(s_tvalid_z), .s_axis_tlast(s_tlast_z),
        .s_axis_tready(s_tready_z),
        .m_axis_tdata(m_tdata_z), .m_axis_tvalid(m_tvalid_z), .m_axis_tlast(m_tlast_z),
        .m_axis_tready(m_tready_z),
        .grant_id(grant_z), .busy(busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Source generator state
    int   cnt[2];
    int   len[2];
    int   frames_left[2];
    int   base[2];
    int   step[2];
    bit   lastff[2];
    int   hold_at[2];
    int   hold_rem[2];
    logic [1:0] hs_pend;
    logic rst_drv;
    bit   rand_rdy;
    bit   chk_mirror;

    // Monitor state
    bit   in_frame;
    int   idle_cnt;
    int   holes;
    int   gap_cur;
    int   beats;
    int   nfr;
    int   fr_grant[16];
    int   fr_holes[16];
    int   fr_gap[16];
    int   viol;
    int   mirror_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int i, input int idx);
        if (lastff[i] && idx == len[i] - 1) return 8'hFF;
        return 8'(base[i] + idx * step[i]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; len[i] = 1; frames_left[i] = 0; base[i] = 0; step[i] = 0;
            lastff[i] = 1'b0; hold_at[i] = -1; hold_rem[i] = 0;
        end
        hs_pend = 2'b00; rand_rdy = 1'b0; chk_mirror = 1'b0;
        in_frame = 1'b0; idle_cnt = 0; holes = 0; gap_cur = 0; beats = 0; nfr = 0;
        viol = 0; mirror_err = 0;
    endtask

    task automatic monitor();
        int g;
        logic [1:0] exp_r;
        g = int'(grant);
        if (!in_frame && m_tvalid === 1'b1) begin
            in_frame = 1'b1; gap_cur = idle_cnt; holes = 0;
        end else if (in_frame && m_tvalid === 1'b0) begin
            holes++;
        end else if (!in_frame && m_tvalid === 1'b0) begin
            idle_cnt++;
        end
        if (chk_mirror) begin
            exp_r = in_frame ? {m_tready, 1'b0} : 2'b00;
            if (s_tready !== exp_r) mirror_err++;
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            beats++;
            chk("m_beat", 32'({m_tlast, m_tdata}),
                32'({(cnt[g] == len[g] - 1), byte_of(g, cnt[g])}));
            if (m_tlast === 1'b1 && nfr < 16) begin
                fr_grant[nfr] = g; fr_holes[nfr] = holes; fr_gap[nfr] = gap_cur;
                nfr++;
                in_frame = 1'b0; idle_cnt = 0;
            end
        end
        hs_pend = s_tvalid & s_tready;
        if ($countones(s_tready) > 1) viol++;
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            if (hs_pend[i]) begin
                cnt[i]++;
                if (cnt[i] == len[i]) begin
                    cnt[i] = 0;
                    frames_left[i]--;
                end
            end
        end
        hs_pend = 2'b00;
        @(posedge clk);
        #1;
        rst = rst_drv;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < 2; i++) begin
            logic v;
            v = (frames_left[i] > 0);
            if (v && cnt[i] == hold_at[i] && hold_rem[i] > 0) begin
                v = 1'b0;
                hold_rem[i]--;
            end
            s_tvalid[i]      = v;
            s_tdata[8*i +: 8] = (frames_left[i] > 0) ? byte_of(i, cnt[i]) : 8'h00;
            s_tlast[i]       = (frames_left[i] > 0) && (cnt[i] == len[i] - 1);
        end
        #4;
        monitor();
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        tick();
        tick();
        rst_drv = 1'b0;
        clear_model();
    endtask

    task automatic run_until(input int nf, input int budget);
        int k;
        k = 0;
        while (nfr < nf && k < budget) begin
            tick();
            k++;
        end
        chk("frames_done", 32'(nfr), 32'(nf));
    endtask

    initial begin
        int zg[8];
        int zt[8];
        int zd[8];
        int nz;
        int k;

        rst = 1'b1; rst_drv = 1'b1;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        s_tdata_z = 16'h2211; s_tvalid_z = 2'b00; s_tlast_z = 2'b11; m_tready_z = 1'b1;
        clear_model();

        // Test 1: single 64-byte frame from source 0
        do_reset();
        chk("rst_s_tready", 32'(s_tready), 32'h0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("rst_m_tdata",  32'(m_tdata),  32'h0);
        chk("rst_m_tlast",  32'(m_tlast),  32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_grant",    32'(grant),    32'h0);
        len[0] = 64; frames_left[0] = 1; base[0] = 8'hAA; step[0] = 0; lastff[0] = 1'b1;
        tick();
        chk("t1_idle_tvalid", 32'(m_tvalid), 32'h0);
        chk("t1_idle_busy",   32'(busy),     32'h0);
        tick();
        chk("t1_first_tvalid", 32'(m_tvalid), 32'h1);
        chk("t1_first_grant",  32'(grant),    32'h0);
        chk("t1_first_busy",   32'(busy),     32'h1);
        run_until(1, 200);
        chk("t1_beats", 32'(beats), 32'd64);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_gap_busy",   32'(busy),     32'h1);
            chk("t1_gap_tvalid", 32'(m_tvalid), 32'h0);
        end
        tick();
        chk("t1_idle_after_gap", 32'(busy), 32'h0);

        // Test 2: both sources with four 8-byte frames each
        do_reset();
        for (int i = 0; i < 2; i++) begin
            len[i] = 8; frames_left[i] = 4; base[i] = 8'h40 * i; step[i] = 1;
        end
        run_until(8, 400);
        for (int f = 0; f < 8; f++) begin
            chk("t2_grant_seq", 32'(fr_grant[f]), 32'(f % 2));
            if (f > 0) chk("t2_idle_between", 32'(fr_gap[f]), 32'd5);
        end
        chk("t2_ready_onehot", 32'(viol), 32'h0);

        // Test 3: source 0 drops valid mid-frame while source 1 waits
        do_reset();
        len[0] = 16; frames_left[0] = 1; base[0] = 8'h10; step[0] = 1;
        hold_at[0] = 5; hold_rem[0] = 3;
        len[1] = 8; frames_left[1] = 1; base[1] = 8'h60; step[1] = 1;
        run_until(2, 200);
        chk("t3_grant0", 32'(fr_grant[0]), 32'h0);
        chk("t3_holes0", 32'(fr_holes[0]), 32'd3);
        chk("t3_grant1", 32'(fr_grant[1]), 32'h1);
        chk("t3_gap1",   32'(fr_gap[1]),   32'd5);
        chk("t3_ready_onehot", 32'(viol), 32'h0);

        // Test 4: random backpressure, 20-byte frame from source 1
        do_reset();
        len[1] = 20; frames_left[1] = 1; base[1] = 8'h80; step[1] = 3;
        rand_rdy = 1'b1; chk_mirror = 1'b1;
        run_until(1, 300);
        chk("t4_grant",  32'(fr_grant[0]), 32'h1);
        chk("t4_beats",  32'(beats),       32'd20);
        chk("t4_mirror", 32'(mirror_err),  32'h0);
        rand_rdy = 1'b0; chk_mirror = 1'b0;

        // Test 5: zero-gap instance with 1-byte frames from both sources
        s_tvalid_z = 2'b11;
        do_reset();
        nz = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_tvalid_z === 1'b1 && m_tready_z === 1'b1 && nz < 8) begin
                zg[nz] = int'(grant_z); zt[nz] = c; zd[nz] = int'(m_tdata_z);
                nz++;
            end
        end
        chk("t5_count", 32'(nz >= 5), 32'h1);
        if (nz >= 5) begin
            chk("t5_first_time", 32'(zt[0]), 32'd1);
            for (int f = 0; f < 5; f++) begin
                chk("t5_grant", 32'(zg[f]), 32'(f % 2));
                chk("t5_data",  32'(zd[f]), (f % 2) ? 32'h22 : 32'h11);
                if (f > 0) chk("t5_spacing", 32'(zt[f] - zt[f-1]), 32'd2);
            end
        end
        s_tvalid_z = 2'b00;

        // Test 6: reset at byte 10 of a 64-byte frame
        do_reset();
        len[0] = 64; frames_left[0] = 1; base[0] = 8'h00; step[0] = 1;
        len[1] = 8;  frames_left[1] = 1; base[1] = 8'h40; step[1] = 1;
        k = 0;
        while (beats < 10 && k < 100) begin
            tick();
            k++;
        end
        chk("t6_reached_byte10", 32'(beats >= 10), 32'h1);
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        clear_model();
        len[0] = 64; frames_left[0] = 1; base[0] = 8'h00; step[0] = 1;
        len[1] = 8;  frames_left[1] = 1; base[1] = 8'h40; step[1] = 1;
        tick();
        chk("t6_s_tready", 32'(s_tready), 32'h0);
        chk("t6_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("t6_busy",     32'(busy),     32'h0);
        tick();
        chk("t6_regrant_valid", 32'(m_tvalid), 32'h1);
        chk("t6_regrant_id",    32'(grant),    32'h0);
        chk("t6_regrant_data",  32'(m_tdata),  32'h00);
        run_until(2, 300);
        chk("t6_order0", 32'(fr_grant[0]), 32'h0);
        chk("t6_order1", 32'(fr_grant[1]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
